// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for six seven-segment digits that share
// one BCD-to-segment decoder.
//
// Ports
//   CLK        system clock, all state changes on the rising edge
//   nRST       asynchronous active-low reset
//   SCANEN     one-cycle tick requesting advance to the next digit slot
//   BLINKEN    one-cycle tick toggling the blink phase
//   DIGITS     six BCD digits, DIGITS[4k+3:4k] = digit k (0 = sec ones,
//              5 = hours tens)
//   BLINKMASK  bit k set = digit k blinks (sampled live)
//   LZB        leading-zero blank enable for digit 5
//   DOUT       BCD value to the shared decoder
//   DEN        shared decoder enable, 0 = all segments off
//   nDIG       active-low one-hot digit select
//
// Every DRIVE slot is separated by BLANK_CYC clocks with all digits off, so
// segment data never changes while a digit common is driven.

module seg7_scan #(
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        SCANEN,
  input  logic        BLINKEN,
  input  logic [23:0] DIGITS,
  input  logic [5:0]  BLINKMASK,
  input  logic        LZB,
  output logic [3:0]  DOUT,
  output logic        DEN,
  output logic [5:0]  nDIG
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic        ph_q,    ph_d;
  logic [23:0] snap_q,  snap_d;
  logic [3:0]  dout_q,  dout_d;
  logic        den_q,   den_d;
  logic [5:0]  ndig_q,  ndig_d;
  logic [3:0]  dig_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_BLANK;
      cnt_q   <= BLANK_INIT;
      idx_q   <= '0;
      ph_q    <= 1'b0;
      snap_q  <= '0;
      dout_q  <= '0;
      den_q   <= 1'b0;
      ndig_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
      ndig_q  <= ndig_d;
    end
  end

  // Next-state: blank down-counter, slot advance and frame snapshot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ph_d    = ph_q ^ BLINKEN;

    unique case (state_q)
      ST_BLANK: begin
        // SCANEN is deliberately not looked at here: no queued advance.
        if (cnt_q <= 4'd1) begin
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (SCANEN) begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_INIT;
          if (idx_q == 3'd5) begin
            idx_d  = '0;
            snap_d = DIGITS;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Outputs are decoded from the next-state values so DOUT, DEN and nDIG
  // leave the flops on the same edge as the state they describe.
  always_comb begin
    unique case (idx_d)
      3'd0:    dig_d = snap_d[3:0];
      3'd1:    dig_d = snap_d[7:4];
      3'd2:    dig_d = snap_d[11:8];
      3'd3:    dig_d = snap_d[15:12];
      3'd4:    dig_d = snap_d[19:16];
      3'd5:    dig_d = snap_d[23:20];
      default: dig_d = '0;
    endcase

    ndig_d = '1;
    dout_d = '0;
    den_d  = 1'b0;
    if (state_d == ST_DRIVE) begin
      ndig_d = ~(6'b000001 << idx_d);
      dout_d = dig_d;
      den_d  = !(BLINKMASK[idx_d] && ph_d)
            && !(LZB && (idx_d == 3'd5) && (dig_d == 4'd0))
            && (dig_d <= 4'd9);
    end
  end

  assign DOUT = dout_q;
  assign DEN  = den_q;
  assign nDIG = ndig_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan. Two instances (BLANK_CYC=1 and 3) share
// every input; a slot-level reference model predicts each output cycle.

module tb_seg7_scan;

  localparam int BC0 = 1;
  localparam int BC1 = 3;

  logic        CLK, nRST, SCANEN, BLINKEN, LZB;
  logic [23:0] DIGITS;
  logic [5:0]  BLINKMASK;
  logic [3:0]  dout1, dout3;
  logic        den1, den3;
  logic [5:0]  ndig1, ndig3;

  logic [3:0]  o_dout[2];
  logic        o_den[2];
  logic [5:0]  o_ndig[2];
  assign o_dout[0] = dout1;
  assign o_dout[1] = dout3;
  assign o_den[0]  = den1;
  assign o_den[1]  = den3;
  assign o_ndig[0] = ndig1;
  assign o_ndig[1] = ndig3;

  seg7_scan #(.BLANK_CYC(BC0)) dut1 (
    .CLK(CLK), .nRST(nRST), .SCANEN(SCANEN), .BLINKEN(BLINKEN),
    .DIGITS(DIGITS), .BLINKMASK(BLINKMASK), .LZB(LZB),
    .DOUT(dout1), .DEN(den1), .nDIG(ndig1)
  );

  seg7_scan #(.BLANK_CYC(BC1)) dut3 (
    .CLK(CLK), .nRST(nRST), .SCANEN(SCANEN), .BLINKEN(BLINKEN),
    .DIGITS(DIGITS), .BLINKMASK(BLINKMASK), .LZB(LZB),
    .DOUT(dout3), .DEN(den3), .nDIG(ndig3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: "is blanking, clocks left, slot, phase, frame digits".
  bit         m_blank[2];
  int         m_left[2];
  int         m_idx[2];
  bit         m_ph[2];
  int         m_snap[2][6];
  logic [3:0] e_dout[2];
  logic       e_den[2];
  logic [5:0] e_ndig[2];

  // First-cycle observations of each DRIVE slot of the BLANK_CYC=1 instance.
  logic [3:0] rec_dout[$];
  logic       rec_den[$];
  logic [5:0] rec_ndig[$];
  logic [5:0] prev_ndig1;

  function automatic int bc_of(input int k);
    return (k == 0) ? BC0 : BC1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_blank[k] = 1'b1;
      m_left[k]  = bc_of(k);
      m_idx[k]   = 0;
      m_ph[k]    = 1'b0;
      for (int j = 0; j < 6; j++) m_snap[k][j] = 0;
      e_dout[k] = 4'h0;
      e_den[k]  = 1'b0;
      e_ndig[k] = 6'h3F;
    end
  endtask

  task automatic model_edge(input bit scan, input bit blink);
    int d;
    for (int k = 0; k < 2; k++) begin
      if (m_blank[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) m_blank[k] = 1'b0;
      end else if (scan) begin
        m_blank[k] = 1'b1;
        m_left[k]  = bc_of(k);
        if (m_idx[k] == 5) begin
          m_idx[k] = 0;
          for (int j = 0; j < 6; j++) m_snap[k][j] = int'((DIGITS >> (4 * j)) & 24'hF);
        end else begin
          m_idx[k]++;
        end
      end
      if (blink) m_ph[k] = !m_ph[k];
      if (m_blank[k]) begin
        e_ndig[k] = 6'h3F;
        e_den[k]  = 1'b0;
        e_dout[k] = 4'h0;
      end else begin
        d = m_snap[k][m_idx[k]];
        e_ndig[k] = 6'h3F & ~(6'd1 << m_idx[k]);
        e_dout[k] = 4'(d);
        e_den[k]  = !(BLINKMASK[m_idx[k]] && m_ph[k]) && !(LZB && m_idx[k] == 5 && d == 0) && (d < 10);
      end
    end
  endtask

  // One clock: inputs applied after the previous edge, outputs settle #1 after this one.
  task automatic tick(input bit scan, input bit blink);
    SCANEN  = scan;
    BLINKEN = blink;
    @(posedge CLK);
    model_edge(scan, blink);
    #1;
    if (ndig1 != 6'h3F && prev_ndig1 == 6'h3F) begin
      rec_dout.push_back(dout1);
      rec_den.push_back(den1);
      rec_ndig.push_back(ndig1);
    end
    prev_ndig1 = ndig1;
  endtask

  task automatic hard_reset();
    SCANEN  = 1'b0;
    BLINKEN = 1'b0;
    #2 nRST = 1'b0;
    model_reset();
    #2 nRST = 1'b1;
    rec_dout.delete();
    rec_den.delete();
    rec_ndig.delete();
    prev_ndig1 = 6'h3F;
  endtask

  task automatic test_reset();
    nRST = 1'b1; SCANEN = 1'b0; BLINKEN = 1'b0;
    DIGITS = 24'h000000; BLINKMASK = 6'h00; LZB = 1'b0;
    prev_ndig1 = 6'h3F;
    #1 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_ndig[k] !== 6'h3F || o_den[k] !== 1'b0 || o_dout[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold inst%0d: ndig=%b den=%b dout=%h, expected ndig=111111 den=0 dout=0",
                 k, o_ndig[k], o_den[k], o_dout[k]);
      end
    end
    model_reset();
    #2 nRST = 1'b1;
    DIGITS = 24'h987654;
    tick(1'b0, 1'b0);
    n_cmp++;
    if (ndig1 !== 6'b111110 || dout1 !== 4'h0 || den1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_drive: ndig=%b dout=%h den=%b, expected ndig=111110 dout=0 den=1",
               ndig1, dout1, den1);
    end
    // Run into slot 4, then pulse reset between clock edges.
    for (int c = 0; c < 200 && !(m_idx[0] == 4 && !m_blank[0]); c++) begin
      tick(c % 8 == 7, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL reset_run inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
    end
    n_cmp++;
    if (ndig1 !== 6'b101111) begin
      n_fail++;
      $display("FAIL reset_slot4_reached: ndig=%b, expected 101111", ndig1);
    end
    #2 nRST = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_ndig[k] !== 6'h3F || o_den[k] !== 1'b0 || o_dout[k] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_async inst%0d: ndig=%b den=%b dout=%h, expected ndig=111111 den=0 dout=0",
                 k, o_ndig[k], o_den[k], o_dout[k]);
      end
    end
    model_reset();
    #1 nRST = 1'b1;
    prev_ndig1 = 6'h3F;
    tick(1'b0, 1'b0);
    n_cmp++;
    if (ndig1 !== 6'b111110 || dout1 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: ndig=%b dout=%h, expected ndig=111110 dout=0", ndig1, dout1);
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] exp_seq[6];
    int blank_run;
    bit seen_drive;
    exp_seq = '{4'h7, 4'h1, 4'h9, 4'h5, 4'h3, 4'h2};
    DIGITS = 24'h235917; BLINKMASK = 6'h00; LZB = 1'b0;
    hard_reset();
    blank_run = 0;
    seen_drive = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick(c % 8 == 7, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL scan_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      if (ndig1 == 6'h3F) begin
        blank_run++;
      end else begin
        if (seen_drive && blank_run != 0) begin
          n_cmp++;
          if (blank_run != 1) begin
            n_fail++;
            $display("FAIL scan_blank_gap: %0d blank cycles between slots, expected 1", blank_run);
          end
        end
        blank_run = 0;
        seen_drive = 1'b1;
      end
    end
    n_cmp++;
    if (rec_dout.size() < 12) begin
      n_fail++;
      $display("FAIL scan_slot_count: %0d slots seen, expected at least 12", rec_dout.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (rec_dout[6+i] !== exp_seq[i] || rec_ndig[6+i] !== (6'h3F ^ (6'd1 << i)) || rec_den[6+i] !== 1'b1) begin
          n_fail++;
          $display("FAIL scan_frame2 slot%0d: dout=%h ndig=%b den=%b, expected dout=%h ndig=%b den=1",
                   i, rec_dout[6+i], rec_ndig[6+i], rec_den[6+i], exp_seq[i], 6'h3F ^ (6'd1 << i));
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] exp_seq[12];
    bit changed;
    exp_seq = '{4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    DIGITS = 24'h123456; BLINKMASK = 6'h00; LZB = 1'b0;
    hard_reset();
    changed = 1'b0;
    for (int c = 0; c < 150; c++) begin
      tick(c % 8 == 7, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL snap_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      // Ninth slot = slot 2 of the first frame showing 123456.
      if (!changed && rec_dout.size() == 9) begin
        DIGITS = 24'h654321;
        changed = 1'b1;
      end
    end
    n_cmp++;
    if (rec_dout.size() < 18) begin
      n_fail++;
      $display("FAIL snap_slot_count: %0d slots seen, expected at least 18", rec_dout.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (rec_dout[6+i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL snap_seq slot%0d: dout=%h, expected %h", 6 + i, rec_dout[6+i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_blink();
    int idx;
    logic exp_den;
    DIGITS = 24'h123456; BLINKMASK = 6'b000011; LZB = 1'b0;
    hard_reset();
    for (int c = 0; c < 200; c++) begin
      tick(c % 4 == 3, c % 13 == 5);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL blink_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      if (ndig1 != 6'h3F) begin
        idx = 0;
        for (int j = 0; j < 6; j++) if (ndig1[j] == 1'b0) idx = j;
        exp_den = (idx < 2) ? !m_ph[0] : 1'b1;
        n_cmp++;
        if (den1 !== exp_den) begin
          n_fail++;
          $display("FAIL blink_den digit%0d ph=%0d: den=%b, expected %b", idx, m_ph[0], den1, exp_den);
        end
      end
    end
  endtask

  task automatic test_lzb_nonbcd();
    logic [3:0] exp_dout[6];
    logic       exp_den[6];
    exp_dout = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'h0};
    exp_den  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    DIGITS = 24'h05A321; BLINKMASK = 6'h00; LZB = 1'b1;
    hard_reset();
    for (int c = 0; c < 150; c++) begin
      tick(c % 8 == 7, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL lzb_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      if (rec_dout.size() == 12) LZB = 1'b0;
    end
    n_cmp++;
    if (rec_dout.size() < 18) begin
      n_fail++;
      $display("FAIL lzb_slot_count: %0d slots seen, expected at least 18", rec_dout.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (rec_dout[6+i] !== exp_dout[i] || rec_den[6+i] !== exp_den[i]) begin
          n_fail++;
          $display("FAIL lzb_on slot%0d: dout=%h den=%b, expected dout=%h den=%b",
                   i, rec_dout[6+i], rec_den[6+i], exp_dout[i], exp_den[i]);
        end
      end
      n_cmp++;
      if (rec_dout[17] !== 4'h0 || rec_den[17] !== 1'b1) begin
        n_fail++;
        $display("FAIL lzb_off slot5: dout=%h den=%b, expected dout=0 den=1", rec_dout[17], rec_den[17]);
      end
      n_cmp++;
      if (rec_dout[15] !== 4'hA || rec_den[15] !== 1'b0) begin
        n_fail++;
        $display("FAIL nonbcd slot3: dout=%h den=%b, expected dout=a den=0", rec_dout[15], rec_den[15]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int drive_run, blank_run, ndrv;
    bit seen_drive;
    DIGITS = 24'h314159; BLINKMASK = 6'h00; LZB = 1'b0;
    hard_reset();
    drive_run = 0; blank_run = 0; seen_drive = 1'b0;
    // SCANEN held high: slot length collapses to one clock.
    for (int c = 0; c < 60; c++) begin
      tick(1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL b2b_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      if (ndig3 == 6'h3F) begin
        if (drive_run != 0) begin
          n_cmp++;
          if (drive_run != 1) begin
            n_fail++;
            $display("FAIL b2b_drive_len: %0d clocks, expected 1", drive_run);
          end
        end
        drive_run = 0;
        blank_run++;
      end else begin
        if (seen_drive && blank_run != 0) begin
          n_cmp++;
          if (blank_run != 3) begin
            n_fail++;
            $display("FAIL b2b_blank_len: %0d clocks, expected 3", blank_run);
          end
        end
        blank_run = 0;
        seen_drive = 1'b1;
        drive_run++;
      end
    end
    // SCANEN and BLINKEN together every clock, all digits blink-masked:
    // the phase is 1 on every DRIVE edge of the BLANK_CYC=1 instance.
    BLINKMASK = 6'h3F;
    hard_reset();
    ndrv = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL simul_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
      if (ndig1 != 6'h3F) begin
        n_cmp++;
        if (den1 !== 1'b0 || ndig1 !== (6'h3F ^ (6'd1 << (ndrv % 6)))) begin
          n_fail++;
          $display("FAIL simul_drive%0d: den=%b ndig=%b, expected den=0 ndig=%b",
                   ndrv, den1, ndig1, 6'h3F ^ (6'd1 << (ndrv % 6)));
        end
        ndrv++;
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] dg;
    hard_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        for (int j = 0; j < 6; j++) dg[4*j +: 4] = 4'($urandom_range(0, 11));
        DIGITS = dg;
      end
      if ($urandom_range(0, 9) == 0) BLINKMASK = 6'($urandom);
      if ($urandom_range(0, 9) == 0) LZB = 1'($urandom);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_dout[k] !== e_dout[k] || o_den[k] !== e_den[k] || o_ndig[k] !== e_ndig[k]) begin
          n_fail++;
          $display("FAIL random_model inst%0d t=%0t: dout=%h den=%b ndig=%b, expected dout=%h den=%b ndig=%b",
                   k, $time, o_dout[k], o_den[k], o_ndig[k], e_dout[k], e_den[k], e_ndig[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_snapshot();
    test_blink();
    test_lzb_nonbcd();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 1, meaning number of clock cycles all digits are off between two digit slots (legal range 1..15).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port SCANEN  input  1  one-cycle scan tick; requests advance to the next digit.
REQ-005 SHALL have port BLINKEN  input  1  one-cycle blink tick; toggles blink phase.
REQ-006 SHALL have port DIGITS  input  24  six BCD digits; DIGITS[4k+3:4k] = digit k, where digit 0 is seconds ones and digit 5 is hours tens.
REQ-007 SHALL have port BLINKMASK  input  6  bit k set = digit k blinks.
REQ-008 SHALL have port LZB  input  1  leading-zero blank enable for digit 5.
REQ-009 SHALL have port DOUT  output  4  BCD value for the shared seven-segment decoder data input.
REQ-010 SHALL have port DEN  output  1  enable for the shared decoder; 0 = all segments off.
REQ-011 SHALL have port nDIG  output  6  active-low one-hot digit select; bit k low = digit k common driven.

Function
REQ-012 SHALL time-multiplex one decoder across six digits using a slot index IDX, 0..5, wrapping 5->0.
REQ-013 SHALL implement two states: BLANK (nDIG=6'b111111, DEN=0) and DRIVE (nDIG bit IDX low, others high).
REQ-014 SHALL stay in BLANK for exactly BLANK_CYC clocks (down-counter), then enter DRIVE on the next edge; SCANEN in BLANK is ignored, not queued.
REQ-015 SHALL, in DRIVE on SCANEN=1, enter BLANK and advance IDX on the same edge; without SCANEN, DRIVE holds indefinitely.
REQ-016 SHALL capture all 24 DIGITS bits into a frame snapshot on the edge where IDX wraps 5->0, so one scan frame never mixes old and new digits.
REQ-017 SHALL drive DOUT = snapshot digit IDX while in DRIVE, and DOUT = 4'h0 while in BLANK.
REQ-018 SHALL toggle blink phase PH on every BLINKEN=1, in any state; PH=1 means blinking digits are off.
REQ-019 SHALL force DEN=0 in DRIVE when BLINKMASK[IDX]=1 and PH=1; BLINKMASK is sampled live, not snapshotted.
REQ-020 SHALL force DEN=0 in DRIVE when LZB=1, IDX=5 and the snapshot digit 5 = 0.
REQ-021 SHALL force DEN=0 in DRIVE when the snapshot digit is greater than 9, so the decoder never sees a non-BCD code while enabled.
REQ-022 SHALL otherwise set DEN=1 in DRIVE.
REQ-023 SHALL register DOUT, DEN and nDIG so all three change on the same clock edge; nDIG never has more than one bit low.
REQ-024 SHALL, when SCANEN and BLINKEN occur in the same cycle, apply both: IDX advances and PH toggles.

Reset
REQ-025 SHALL, while nRST=0, hold state=BLANK, IDX=0, blank counter=BLANK_CYC, PH=0, snapshot=24'h0, nDIG=6'b111111, DEN=0, DOUT=4'h0, independent of CLK.
REQ-026 SHALL, after nRST deasserts, spend BLANK_CYC clocks in BLANK, then enter DRIVE on digit 0 with the snapshot still 0 until the first wrap.
REQ-027 SHALL, on reset asserted mid-frame, return immediately to the REQ-025 values; no partial-frame state survives.

Verification
REQ-028 SHALL cover full scan: BLANK_CYC=1, DIGITS=24'h235917, SCANEN every 8 clocks, run two frames -> second frame shows DOUT 7,1,9,5,3,2 on nDIG 111110..011111, with one all-high cycle between slots.
REQ-029 SHALL cover snapshot: change DIGITS from 24'h123456 to 24'h654321 during slot 2 -> remaining slots of that frame show 3,2,1; the next frame shows 1..6 order of the new value.
REQ-030 SHALL cover blink: BLINKMASK=6'b000011, BLINKEN pulsed -> digits 0 and 1 show DEN=0 while PH=1 and DEN=1 while PH=0; other digits always DEN=1.
REQ-031 SHALL cover leading zero and non-BCD: LZB=1, digit 5=0 -> DEN=0 in slot 5; LZB=0 -> DEN=1 with DOUT=0; digit 3=4'hA -> DEN=0 in slot 3.
REQ-032 SHALL cover guard and simultaneous events: SCANEN held high continuously with BLANK_CYC=3 -> each DRIVE lasts 1 clock and each BLANK lasts 3 clocks; SCANEN and BLINKEN together -> IDX advances and PH toggles.
REQ-033 SHALL cover reset: nRST pulsed low in slot 4 between clock edges -> outputs take the REQ-025 values immediately; after release, the first DRIVE is digit 0 with DOUT=0.
